// File: rtl/fsk_phase_sequencer_pkg.sv
// Shared definitions for the FSK phase sequencer.
// Radio-wide widths, defaults and FSM state encodings.
package fsk_phase_sequencer_pkg;

  localparam int FSK_PHASE_BITS     = 25;
  localparam int FSK_SYMBOL_SAMPLES = 64;
  localparam int PRECISION          = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsk_state_t;

endpackage

// File: rtl/fsk_phase_sequencer_if.sv
// Symbol stream valid/ready bundle.
// The source drives master, the sequencer takes slave.
interface fsk_phase_sequencer_if #(
  parameter int SYM_BITS = 2
);
  logic                valid;
  logic [SYM_BITS-1:0] data;
  logic                last;
  logic                ready;

  modport master (
    output valid, data, last,
    input  ready
  );

  modport slave (
    input  valid, data, last,
    output ready
  );
endinterface

// File: rtl/fsk_phase_sequencer_freq_map.sv
// Symbol to frequency word mapping.
// freq = base + sym * dev, wrapping modulo the phase circle.
module fsk_phase_sequencer_freq_map #(
  parameter int SYM_BITS   = 2,
  parameter int PHASE_BITS = 25
) (
  input  logic [SYM_BITS-1:0]   sym,
  input  logic [PHASE_BITS-1:0] base,
  input  logic [PHASE_BITS-1:0] dev,
  output logic [PHASE_BITS-1:0] freq
);

  // Truncation to PHASE_BITS gives the modulo wrap for free.
  assign freq = base + PHASE_BITS'(sym) * dev;

endmodule

// File: rtl/fsk_phase_sequencer.sv
// FSK symbol sequencer: next-symbol buffer, FSM,
// sample counter and phase-continuous accumulator.
module fsk_phase_sequencer
  import fsk_phase_sequencer_pkg::*;
#(
  parameter int SYM_BITS       = 2,
  parameter int SYMBOL_SAMPLES = FSK_SYMBOL_SAMPLES,
  parameter int PHASE_BITS     = FSK_PHASE_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  sample_tick,
  input  logic [PHASE_BITS-1:0] base_freq,
  input  logic [PHASE_BITS-1:0] dev_step,
  fsk_phase_sequencer_if.slave  sym,
  output logic [PRECISION-1:0]  angle,
  output logic                  angle_valid,
  output logic                  sym_start,
  output logic                  busy,
  output logic                  underrun
);

  localparam int CW = $clog2(SYMBOL_SAMPLES);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(SYMBOL_SAMPLES - 1);

  fsk_state_t state;

  logic                  next_full;
  logic [SYM_BITS-1:0]   next_data;
  logic                  next_last;
  logic                  cur_last;
  logic [PHASE_BITS-1:0] cur_freq;
  logic [PHASE_BITS-1:0] acc;
  logic [PHASE_BITS-1:0] map_freq;
  logic [CW-1:0]         cnt;

  logic xfer;
  logic sym_end;
  logic idle_load;
  logic run_load;
  logic consume;

  assign sym.ready = ~next_full;
  assign xfer      = sym.valid & ~next_full;

  assign sym_end   = (state == ST_RUN) &&
                     sample_tick && (cnt == CNT_LAST);
  assign idle_load = (state == ST_IDLE) &&
                     tx_en && next_full;
  assign run_load  = sym_end && !cur_last &&
                     tx_en && next_full;
  assign consume   = idle_load | run_load;

  assign busy  = (state == ST_RUN);
  assign angle = PRECISION'(acc);

  fsk_phase_sequencer_freq_map #(
    .SYM_BITS   (SYM_BITS),
    .PHASE_BITS (PHASE_BITS)
  ) u_map (
    .sym  (next_data),
    .base (base_freq),
    .dev  (dev_step),
    .freq (map_freq)
  );

  // One-deep next-symbol buffer; a write wins over a consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_full <= 1'b0;
      next_data <= '0;
      next_last <= 1'b0;
    end else begin
      if (xfer) begin
        next_data <= sym.data;
        next_last <= sym.last;
      end
      next_full <= xfer | (next_full & ~consume);
    end
  end

  // Symbol FSM, sample counter and phase accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      acc         <= '0;
      cur_freq    <= '0;
      cur_last    <= 1'b0;
      cnt         <= '0;
      angle_valid <= 1'b0;
      sym_start   <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      angle_valid <= 1'b0;
      sym_start   <= 1'b0;
      underrun    <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (idle_load) begin
            state    <= ST_RUN;
            acc      <= '0;
            cnt      <= '0;
            cur_freq <= map_freq;
            cur_last <= next_last;
          end
        end
        ST_RUN: begin
          if (sample_tick) begin
            acc         <= acc + cur_freq;
            angle_valid <= 1'b1;
            sym_start   <= (cnt == '0);
            if (cnt == CNT_LAST) begin
              if (cur_last || !tx_en) begin
                state <= ST_IDLE;
              end else if (next_full) begin
                cnt      <= '0;
                cur_freq <= map_freq;
                cur_last <= next_last;
              end else begin
                underrun <= 1'b1;
                state    <= ST_IDLE;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_phase_sequencer.sv
// Bench for fsk_phase_sequencer: scoreboard of expected
// angles pushed per symbol, popped on each angle_valid.
module tb_fsk_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_en;
  logic        sample_tick;
  logic [24:0] base_freq;
  logic [24:0] dev_step;
  logic [31:0] angle;
  logic        angle_valid;
  logic        sym_start;
  logic        busy;
  logic        underrun;

  fsk_phase_sequencer_if #(.SYM_BITS(2)) sif ();

  fsk_phase_sequencer #(
    .SYM_BITS       (2),
    .SYMBOL_SAMPLES (4),
    .PHASE_BITS     (25)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_en       (tx_en),
    .sample_tick (sample_tick),
    .base_freq   (base_freq),
    .dev_step    (dev_step),
    .sym         (sif),
    .angle       (angle),
    .angle_valid (angle_valid),
    .sym_start   (sym_start),
    .busy        (busy),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic        s;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          failures = 0;
  logic [24:0] m_acc;
  int          ur_cnt = 0;
  int          ur_av  = 0;
  int          rlow   = 0;
  int          rmax   = 0;
  int          tick_cnt;

  // Sample tick every third clock.
  initial begin
    tick_cnt    = 0;
    sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_cnt    = (tick_cnt == 2) ? 0 : tick_cnt + 1;
      sample_tick = (tick_cnt == 0);
    end
  end

  // Output monitor and scoreboard pop.
  initial begin
    forever begin
      @(negedge clk);
      if (sif.ready !== 1'b1) rlow++;
      else rlow = 0;
      if (rlow > rmax) rmax = rlow;
      if (underrun === 1'b1) begin
        ur_cnt++;
        if (angle_valid === 1'b1) ur_av++;
      end
      if (angle_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_angle got=%h", angle);
        end else begin
          mon_e = exp_q.pop_front();
          if (angle !== mon_e.a || sym_start !== mon_e.s) begin
            failures++;
            $display("FAIL angle got=%h/%b exp=%h/%b",
                     angle, sym_start, mon_e.a, mon_e.s);
          end
        end
      end
    end
  end

  task automatic push_sym(input logic [1:0] d);
    logic [24:0] f;
    f = base_freq + 25'(d) * dev_step;
    for (int k = 0; k < 4; k++) begin
      m_acc = m_acc + f;
      exp_q.push_back('{a: 32'(m_acc), s: (k == 0)});
    end
  endtask

  task automatic send(input logic [1:0] d, input logic l);
    int n;
    n = 0;
    sif.valid = 1'b1;
    sif.data  = d;
    sif.last  = l;
    while (sif.ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL send_timeout got=ready_low exp=ready_high");
    end
    @(negedge clk);
    sif.valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (n >= 400) begin
      failures++;
      $display("FAIL idle_timeout got=q%0d/busy%b exp=0/0",
               exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (angle !== 32'h0 || angle_valid !== 1'b0 ||
        sym_start !== 1'b0 || busy !== 1'b0 ||
        underrun !== 1'b0 || sif.ready !== 1'b1) begin
      failures++;
      $display("FAIL reset got=%h%b%b%b%b%b exp=0000000000000",
               angle, angle_valid, sym_start, busy,
               underrun, sif.ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    base_freq = 25'h0100000;
    dev_step  = 25'h0080000;
    m_acc     = '0;
    push_sym(2'd2);
    send(2'd2, 1'b1);
    @(negedge clk);
    base_freq = 25'h0001234;
    dev_step  = 25'h0000777;
    wait_idle();
    base_freq = 25'h0100000;
    dev_step  = 25'h0080000;
    checks++;
    if (busy !== 1'b0 || angle !== 32'h0080_0000) begin
      failures++;
      $display("FAIL single_end got=%b/%h exp=0/00800000",
               busy, angle);
    end
  endtask

  task automatic test_back_to_back();
    int ur0;
    ur0   = ur_cnt;
    m_acc = '0;
    push_sym(2'd0);
    push_sym(2'd3);
    rmax = 0;
    send(2'd0, 1'b0);
    send(2'd3, 1'b1);
    wait_idle();
    checks++;
    if (ur_cnt !== ur0) begin
      failures++;
      $display("FAIL b2b_underrun got=%0d exp=0", ur_cnt - ur0);
    end
    checks++;
    if (rmax > 12) begin
      failures++;
      $display("FAIL b2b_ready_low got=%0d exp=<=12", rmax);
    end
    checks++;
    if (angle !== 32'h00E0_0000) begin
      failures++;
      $display("FAIL b2b_angle got=%h exp=00e00000", angle);
    end
  endtask

  task automatic test_wrap();
    base_freq = 25'h1F00000;
    m_acc     = '0;
    push_sym(2'd0);
    send(2'd0, 1'b1);
    wait_idle();
    checks++;
    if (angle !== 32'h01C0_0000) begin
      failures++;
      $display("FAIL wrap_angle got=%h exp=01c00000", angle);
    end
    base_freq = 25'h0100000;
  endtask

  task automatic test_underrun();
    int ur0;
    int av0;
    ur0   = ur_cnt;
    av0   = ur_av;
    m_acc = '0;
    push_sym(2'd1);
    send(2'd1, 1'b0);
    wait_idle();
    @(negedge clk);
    checks++;
    if (ur_cnt - ur0 !== 1 || ur_av - av0 !== 1) begin
      failures++;
      $display("FAIL underrun_pulse got=%0d/%0d exp=1/1",
               ur_cnt - ur0, ur_av - av0);
    end
    checks++;
    if (busy !== 1'b0 || angle !== 32'h0060_0000) begin
      failures++;
      $display("FAIL underrun_hold got=%b/%h exp=0/00600000",
               busy, angle);
    end
  endtask

  task automatic test_simultaneous();
    m_acc = '0;
    push_sym(2'd1);
    push_sym(2'd2);
    push_sym(2'd3);
    send(2'd1, 1'b0);
    send(2'd2, 1'b0);
    send(2'd3, 1'b1);
    checks++;
    if (sif.ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL refill got=%b/%b exp=0/1",
               sif.ready, busy);
    end
    wait_idle();
  endtask

  task automatic test_rst();
    int n;
    m_acc = '0;
    push_sym(2'd2);
    send(2'd2, 1'b0);
    send(2'd1, 1'b0);
    n = 0;
    while (exp_q.size() > 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL rst_wait got=timeout exp=two_angles");
    end
    @(posedge clk);
    #3;
    exp_q.delete();
    rst = 1'b1;
    #1;
    checks++;
    if (angle !== 32'h0 || busy !== 1'b0 ||
        sif.ready !== 1'b1 || angle_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_rst got=%h/%b/%b/%b exp=0/0/1/0",
               angle, busy, sif.ready, angle_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sif.ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_drop got=%b/%b exp=0/1",
               busy, sif.ready);
    end
  endtask

  initial begin
    rst       = 1'b1;
    tx_en     = 1'b1;
    base_freq = 25'h0100000;
    dev_step  = 25'h0080000;
    sif.valid = 1'b0;
    sif.data  = 2'd0;
    sif.last  = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_underrun();
    test_simultaneous();
    test_rst();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
